// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32 execution-unit types
package rv32i_types;

  // funct3[1:0] encoding of the M-extension multiply group
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_CALC = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_sign_fixup.sv
// rtl/mul_sign_fixup.sv - operand magnitude/sign extraction and result negate/half select
module mul_sign_fixup
  import rv32i_types::*;
(
  input  mul_op_t     src_op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] mag_a_o,
  output logic [31:0] mag_b_o,
  output logic        sign_o,
  input  mul_op_t     res_op_i,
  input  logic        res_sign_i,
  input  logic [63:0] acc_i,
  output logic [31:0] result_o
);

  logic        a_neg;
  logic        b_neg;
  logic [63:0] product;

  // Strip signs from the operands that the op treats as signed, then restore the sign on the product
  always_comb begin
    a_neg      = ((src_op_i == MULH) || (src_op_i == MULHSU)) && rs1_i[31];
    b_neg      = (src_op_i == MULH) && rs2_i[31];
    mag_a_o    = a_neg ? (~rs1_i + 32'd1) : rs1_i;
    mag_b_o    = b_neg ? (~rs2_i + 32'd1) : rs2_i;
    sign_o     = a_neg ^ b_neg;
    product    = res_sign_i ? (~acc_i + 64'd1) : acc_i;
    result_o   = (res_op_i == MUL) ? product[31:0] : product[63:32];
  end

endmodule

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative RV32M multiplier feeding the CDB multiply slot
module mul_unit
  import rv32i_types::*;
#(
  parameter int BITS_PER_CYCLE = 2,
  parameter int ROB_IDX_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [1:0]               issue_op,
  input  logic [ROB_IDX_WIDTH-1:0] issue_rob_idx,
  input  logic [4:0]               issue_rd_addr,
  input  logic [31:0]              issue_rs1_data,
  input  logic [31:0]              issue_rs2_data,
  output logic                     mul_valid,
  output logic [ROB_IDX_WIDTH-1:0] mul_rob_idx,
  output logic [4:0]               mul_rd_addr,
  output logic [31:0]              mul_data
);

  localparam int ITERS = 32 / BITS_PER_CYCLE;

  mul_state_t               state_q, state_d;
  mul_op_t                  op_q, op_d;
  logic [ROB_IDX_WIDTH-1:0] rob_q, rob_d;
  logic [4:0]               rd_q, rd_d;
  logic [63:0]              mcand_q, mcand_d;
  logic [31:0]              mplier_q, mplier_d;
  logic [63:0]              acc_q, acc_d;
  logic [5:0]               cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic [31:0]              out_data_q, out_data_d;
  logic [ROB_IDX_WIDTH-1:0] out_rob_q, out_rob_d;
  logic [4:0]               out_rd_q, out_rd_d;

  logic                     accept;
  logic                     load_out;
  logic [63:0]              partial;
  logic [31:0]              mag_a;
  logic [31:0]              mag_b;
  logic                     sign_in;
  logic [31:0]              fix_result;

  mul_sign_fixup u_fixup (
    .src_op_i   (mul_op_t'(issue_op)),
    .rs1_i      (issue_rs1_data),
    .rs2_i      (issue_rs2_data),
    .mag_a_o    (mag_a),
    .mag_b_o    (mag_b),
    .sign_o     (sign_in),
    .res_op_i   (op_q),
    .res_sign_i (sign_q),
    .acc_i      (acc_d),
    .result_o   (fix_result)
  );

  // Next-state, shift-add datapath and handshake/strobe outputs
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rob_d       = rob_q;
    rd_d        = rd_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    load_out    = 1'b0;
    issue_ready = ((state_q == MUL_IDLE) || (state_q == MUL_DONE)) && !flush;
    mul_valid   = (state_q == MUL_DONE) && !flush;
    accept      = issue_valid && issue_ready;
    partial     = mcand_q * {{(64-BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};

    case (state_q)
      MUL_IDLE: begin
        if (accept) state_d = MUL_CALC;
      end
      MUL_CALC: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d  = MUL_DONE;
          load_out = 1'b1;
        end
      end
      MUL_DONE: begin
        state_d = accept ? MUL_CALC : MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase

    if (accept) begin
      op_d     = mul_op_t'(issue_op);
      rob_d    = issue_rob_idx;
      rd_d     = issue_rd_addr;
      mcand_d  = {32'd0, mag_a};
      mplier_d = mag_b;
      sign_d   = sign_in;
      acc_d    = 64'd0;
      cnt_d    = 6'(ITERS);
    end

    if (flush) begin
      state_d  = MUL_IDLE;
      load_out = 1'b0;
    end

    out_data_d = load_out ? fix_result : out_data_q;
    out_rob_d  = load_out ? rob_q      : out_rob_q;
    out_rd_d   = load_out ? rd_q       : out_rd_q;
  end

  // State and datapath registers; async reset drops any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MUL_IDLE;
      op_q       <= MUL;
      rob_q      <= '0;
      rd_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      out_data_q <= '0;
      out_rob_q  <= '0;
      out_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rob_q      <= rob_d;
      rd_q       <= rd_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
      out_rob_q  <= out_rob_d;
      out_rd_q   <= out_rd_d;
    end
  end

  assign mul_data    = out_data_q;
  assign mul_rob_idx = out_rob_q;
  assign mul_rd_addr = out_rd_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - randomized self-checking bench for mul_unit
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [4:0]  issue_rob_idx;
  logic [4:0]  issue_rd_addr;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic        mul_valid;
  logic [4:0]  mul_rob_idx;
  logic [4:0]  mul_rd_addr;
  logic [31:0] mul_data;

  int total = 0;
  int bad   = 0;

  mul_unit #(.BITS_PER_CYCLE(2), .ROB_IDX_WIDTH(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_op       (issue_op),
    .issue_rob_idx  (issue_rob_idx),
    .issue_rd_addr  (issue_rd_addr),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data),
    .mul_valid      (mul_valid),
    .mul_rob_idx    (mul_rob_idx),
    .mul_rd_addr    (mul_rd_addr),
    .mul_data       (mul_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits and multiply modulo 2^64
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rob, input logic [4:0] rd);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_rs1_data = a;
    issue_rs2_data = b;
    issue_rob_idx  = rob;
    issue_rd_addr  = rd;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rob, input logic [4:0] rd);
    @(negedge clk);
    drive(op, a, b, rob, rd);
    chk("accept_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until mul_valid; ready must stay low meanwhile
  task automatic wait_valid(output int n);
    n = 0;
    while (!mul_valid && n < 40) begin
      chk("busy_ready", 64'(issue_ready), 64'd0);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mul_valid) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rob, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    start_op(op, a, b, rob, rd);
    wait_valid(n);
    chk("latency", 64'(n), 64'd16);
    chk("data", 64'(mul_data), 64'(exp));
    chk("rob", 64'(mul_rob_idx), 64'(rob));
    chk("rd", 64'(mul_rd_addr), 64'(rd));
    chk("done_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    chk("one_cycle", 64'(mul_valid), 64'd0);
  endtask

  logic [31:0] pool [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int n;
    int m;
    logic [31:0] a, b, a2, b2;
    logic [1:0]  op;

    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0;
    issue_op = 2'b00; issue_rob_idx = '0; issue_rd_addr = '0;
    issue_rs1_data = '0; issue_rs2_data = '0;
    #2;
    chk("rst_valid", 64'(mul_valid), 64'd0);
    chk("rst_data", 64'(mul_data), 64'd0);
    chk("rst_rob", 64'(mul_rob_idx), 64'd0);
    chk("rst_rd", 64'(mul_rd_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(issue_ready), 64'd1);

    // Directed vectors
    run_op(2'b00, 32'd3, 32'd4, 5'd5, 5'd7, 32'h0000000C);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 5'd2, 32'hFFFFFFFE);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 5'd4, 32'h00000000);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 5'd8, 32'hFFFFFFFF);
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd9, 5'd0, 32'h80000000);
    run_op(2'b01, 32'h80000000, 32'h80000000, 5'd31, 5'd31, 32'h40000000);

    // Randomized against the reference model
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_op(op, a, b, 5'($urandom), 5'($urandom), model(op, a, b));
    end

    // Back-to-back: issue_valid held, second entry accepted in the first's DONE cycle
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    drive(2'b11, a, b, 5'd10, 5'd11);
    @(negedge clk);
    drive(2'b01, a2, b2, 5'd12, 5'd13);
    wait_valid(n);
    chk("b2b_lat1", 64'(n), 64'd16);
    chk("b2b_data1", 64'(mul_data), 64'(model(2'b11, a, b)));
    chk("b2b_rob1", 64'(mul_rob_idx), 64'd10);
    chk("b2b_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    issue_valid = 1'b0;
    m = 1;
    while (!mul_valid && m < 40) begin
      chk("b2b_busy", 64'(issue_ready), 64'd0);
      @(negedge clk);
      m++;
    end
    chk("b2b_gap", 64'(m), 64'd17);
    chk("b2b_data2", 64'(mul_data), 64'(model(2'b01, a2, b2)));
    chk("b2b_rob2", 64'(mul_rob_idx), 64'd12);
    chk("b2b_rd2", 64'(mul_rd_addr), 64'd13);
    @(negedge clk);

    // Flush in CALC cycle 8 with issue_valid high
    start_op(2'b00, 32'd1234, 32'd5678, 5'd14, 5'd15);
    repeat (7) @(negedge clk);
    flush = 1'b1;
    drive(2'b00, 32'd9, 32'd9, 5'd16, 5'd17);
    #1;
    chk("flush_ready", 64'(issue_ready), 64'd0);
    chk("flush_valid", 64'(mul_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("flush_idle_ready", 64'(issue_ready), 64'd1);
    watch_quiet("flush_quiet", 25);
    run_op(2'b00, 32'd2, 32'd2, 5'd18, 5'd19, 32'd4);

    // Flush during DONE suppresses the strobe
    start_op(2'b11, 32'hDEADBEEF, 32'h12345678, 5'd20, 5'd21);
    repeat (16) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_done_valid", 64'(mul_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    watch_quiet("flush_done_quiet", 20);

    // Asynchronous reset between edges mid-CALC
    start_op(2'b00, 32'd77, 32'd88, 5'd22, 5'd23);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(mul_valid), 64'd0);
    chk("arst_data", 64'(mul_data), 64'd0);
    chk("arst_rob", 64'(mul_rob_idx), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_quiet("arst_quiet", 25);
    chk("arst_ready", 64'(issue_ready), 64'd1);
    run_op(2'b00, 32'd6, 32'd7, 5'd24, 5'd25, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
